// File: rtl/jacob_double_seq.sv
// Jacobian point doubling over GF(p) with one bit-serial modular multiplier and one
// modular adder/subtractor, sequenced by a fixed microprogram.
module jacob_double_seq #(
    parameter int W      = 256,
    parameter bit A_ZERO = 1'b0
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] p,
    input  logic [W-1:0] a,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    input  logic [W-1:0] z1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x3,
    output logic [W-1:0] y3,
    output logic [W-1:0] z3,
    output logic         busy
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // out_valid and the result are held until that transfer.
    typedef enum logic [1:0] {S_IDLE, S_INF, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_ADD, OP_SUB} op_t;
    typedef struct packed {
        op_t        op;
        logic [3:0] dst;
        logic [3:0] su;
        logic [3:0] sv;
    } uop_t;

    localparam int CW = $clog2(W + 1);
    localparam logic [4:0] LAST = A_ZERO ? 5'd18 : 5'd22;

    localparam logic [3:0] R_X  = 4'd0,  R_Y  = 4'd1,  R_Z  = 4'd2,  R_A  = 4'd3;
    localparam logic [3:0] R_T1 = 4'd4,  R_T2 = 4'd5,  R_T3 = 4'd6,  R_T4 = 4'd7;
    localparam logic [3:0] R_T5 = 4'd8,  R_T6 = 4'd9,  R_T7 = 4'd10, R_T8 = 4'd11;
    localparam logic [3:0] R_RX = 4'd12, R_RY = 4'd13, R_RZ = 4'd14, R_NIL = 4'd15;

    function automatic uop_t rom(input logic [4:0] i);
        case (i)
            5'd0:    rom = '{OP_MUL, R_T1, R_X,  R_X};
            5'd1:    rom = '{OP_MUL, R_T2, R_Y,  R_Y};
            5'd2:    rom = '{OP_MUL, R_T3, R_T2, R_T2};
            5'd3:    rom = '{OP_MUL, R_T4, R_X,  R_T2};
            5'd4:    rom = '{OP_ADD, R_T4, R_T4, R_T4};
            5'd5:    rom = '{OP_ADD, R_T4, R_T4, R_T4};
            5'd6:    rom = '{OP_MUL, R_T5, R_Z,  R_Z};
            5'd7:    rom = '{OP_MUL, R_T5, R_T5, R_T5};
            5'd8:    rom = '{OP_MUL, R_T5, R_A,  R_T5};
            5'd9:    rom = '{OP_ADD, R_T6, R_T1, R_T1};
            5'd10:   rom = '{OP_ADD, R_T6, R_T6, R_T1};
            5'd11:   rom = '{OP_ADD, R_T6, R_T6, R_T5};
            5'd12:   rom = '{OP_MUL, R_T7, R_T6, R_T6};
            5'd13:   rom = '{OP_SUB, R_T7, R_T7, R_T4};
            5'd14:   rom = '{OP_SUB, R_RX, R_T7, R_T4};
            5'd15:   rom = '{OP_SUB, R_T8, R_T4, R_RX};
            5'd16:   rom = '{OP_MUL, R_T8, R_T6, R_T8};
            5'd17:   rom = '{OP_ADD, R_T3, R_T3, R_T3};
            5'd18:   rom = '{OP_ADD, R_T3, R_T3, R_T3};
            5'd19:   rom = '{OP_ADD, R_T3, R_T3, R_T3};
            5'd20:   rom = '{OP_SUB, R_RY, R_T8, R_T3};
            5'd21:   rom = '{OP_MUL, R_RZ, R_Y,  R_Z};
            5'd22:   rom = '{OP_ADD, R_RZ, R_RZ, R_RZ};
            default: rom = '{OP_ADD, R_NIL, R_X, R_X};
        endcase
    endfunction

    // With a = 0 the a*Z^4 steps (6..8 and 11) are dropped without costing cycles.
    function automatic logic [4:0] map_step(input logic [4:0] j);
        if (!A_ZERO || j < 5'd6)
            map_step = j;
        else if (j < 5'd8)
            map_step = j + 5'd3;
        else
            map_step = j + 5'd4;
    endfunction

    state_t        state, state_n;
    logic [4:0]    step;
    logic [CW-1:0] cnt;
    logic [W-1:0]  p_r;
    logic [W-1:0]  rf [16];
    logic [W+1:0]  mr;
    logic [W-1:0]  mv;

    uop_t          uop;
    logic [W-1:0]  u, v;
    logic [W+1:0]  pe, dbl, red1, acc, mul_next;
    logic [W:0]    sum, diff;
    logic [W-1:0]  sum_red, diff_fix, as_res, wr_data;
    logic          accept, step_end, last_done;

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid & in_ready;

    always_comb begin
        uop      = rom(map_step(step));
        u        = rf[uop.su];
        v        = rf[uop.sv];
        pe       = {2'b00, p_r};
        dbl      = mr << 1;
        red1     = (dbl >= pe) ? dbl - pe : dbl;
        acc      = mv[W-1] ? red1 + {2'b00, u} : red1;
        mul_next = (acc >= pe) ? acc - pe : acc;
        sum      = {1'b0, u} + {1'b0, v};
        sum_red  = W'((sum >= {1'b0, p_r}) ? sum - {1'b0, p_r} : sum);
        diff     = {1'b0, u} - {1'b0, v};
        diff_fix = diff[W] ? diff[W-1:0] + p_r : diff[W-1:0];
        as_res   = (uop.op == OP_SUB) ? diff_fix : sum_red;
        wr_data  = (uop.op == OP_MUL) ? mul_next[W-1:0] : as_res;
        step_end = (uop.op != OP_MUL) || (cnt == CW'(W));
        last_done = (state == S_RUN) && (step == LAST) && step_end;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (accept) state_n = (y1 == '0 || z1 == '0) ? S_INF : S_RUN;
            S_INF:  state_n = S_DONE;
            S_RUN:  if (last_done) state_n = S_DONE;
            S_DONE: if (out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
            step  <= '0;
            cnt   <= '0;
            p_r   <= '0;
            mr    <= '0;
            mv    <= '0;
            x3    <= '0;
            y3    <= '0;
            z3    <= '0;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: if (accept) begin
                    p_r     <= p;
                    rf[R_X] <= x1;
                    rf[R_Y] <= y1;
                    rf[R_Z] <= z1;
                    rf[R_A] <= A_ZERO ? '0 : a;
                    step    <= '0;
                    cnt     <= '0;
                end
                S_INF: begin
                    x3 <= W'(1);
                    y3 <= W'(1);
                    z3 <= '0;
                end
                S_RUN: begin
                    if (uop.op == OP_MUL && cnt == '0) begin
                        mr  <= '0;
                        mv  <= v;
                        cnt <= CW'(1);
                    end else begin
                        if (uop.op == OP_MUL) begin
                            mr <= mul_next;
                            mv <= mv << 1;
                            cnt <= step_end ? '0 : cnt + CW'(1);
                        end
                        if (step_end) begin
                            rf[uop.dst] <= wr_data;
                            step        <= step + 5'd1;
                        end
                    end
                    // The final step writes Z3, so its value is taken straight from the datapath.
                    if (last_done) begin
                        x3 <= rf[R_RX];
                        y3 <= rf[R_RY];
                        z3 <= wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jacob_double_seq.sv
// Directed bench for jacob_double_seq at W=8: one instance with a general a, one with a = 0.
module tb_jacob_double_seq;

    logic       clk, nrst;
    logic [7:0] p, a, x1, y1, z1;
    logic       iv0, iv1, or0, or1;
    logic       rdy0, rdy1, ov0, ov1, busy0, busy1;
    logic [7:0] x30, y30, z30, x31, y31, z31;
    int         checks = 0;
    int         errors = 0;

    jacob_double_seq #(.W(8), .A_ZERO(1'b0)) dut0 (
        .clk(clk), .nrst(nrst), .in_valid(iv0), .in_ready(rdy0),
        .p(p), .a(a), .x1(x1), .y1(y1), .z1(z1),
        .out_valid(ov0), .out_ready(or0), .x3(x30), .y3(y30), .z3(z30), .busy(busy0)
    );

    jacob_double_seq #(.W(8), .A_ZERO(1'b1)) dut1 (
        .clk(clk), .nrst(nrst), .in_valid(iv1), .in_ready(rdy1),
        .p(p), .a(a), .x1(x1), .y1(y1), .z1(z1),
        .out_valid(ov1), .out_ready(or1), .x3(x31), .y3(y31), .z3(z31), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operation; returns cycles from accept to out_valid and the result seen then.
    task automatic drive_op(input bit sel, input logic [7:0] pv, av, xv, yv, zv,
                            output int lat, output logic [7:0] rx, ry, rz);
        int n;
        n = 0;
        @(negedge clk);
        while (!(sel ? rdy1 : rdy0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        p = pv; a = av; x1 = xv; y1 = yv; z1 = zv;
        if (sel) iv1 = 1'b1; else iv0 = 1'b1;
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        iv1 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(sel ? ov1 : ov0) && lat < 300);
        rx = sel ? x31 : x30;
        ry = sel ? y31 : y30;
        rz = sel ? z31 : z30;
    endtask

    task automatic release_out(input bit sel);
        if (sel) or1 = 1'b1; else or0 = 1'b1;
        @(posedge clk);
        #1;
        or0 = 1'b0;
        or1 = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", rdy0); end
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ov0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        checks++; if ({x30, y30, z30} !== 24'h0) begin errors++; $display("FAIL reset_point: got (%0d,%0d,%0d) expected (0,0,0)", x30, y30, z30); end
        checks++; if (rdy1 !== 1'b1 || ov1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_azero_flags: got rdy=%b ov=%b busy=%b expected 1 0 0", rdy1, ov1, busy1); end
    endtask

    task automatic test_double_a1();
        int lat; logic [7:0] rx, ry, rz;
        drive_op(1'b0, 8'd23, 8'd1, 8'd3, 8'd10, 8'd1, lat, rx, ry, rz);
        checks++; if (lat !== 104) begin errors++; $display("FAIL a1_latency: got %0d expected 104", lat); end
        checks++; if ({rx, ry, rz} !== {8'd17, 8'd21, 8'd20}) begin errors++; $display("FAIL a1_point: got (%0d,%0d,%0d) expected (17,21,20)", rx, ry, rz); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL a1_busy_done: got %b expected 1", busy0); end
        release_out(1'b0);
    endtask

    task automatic test_double_azero();
        int lat; logic [7:0] rx, ry, rz;
        drive_op(1'b1, 8'd23, 8'd9, 8'd1, 8'd10, 8'd1, lat, rx, ry, rz);
        checks++; if (lat !== 76) begin errors++; $display("FAIL azero_latency: got %0d expected 76", lat); end
        checks++; if ({rx, ry, rz} !== {8'd14, 8'd2, 8'd20}) begin errors++; $display("FAIL azero_point: got (%0d,%0d,%0d) expected (14,2,20)", rx, ry, rz); end
        release_out(1'b1);
    endtask

    task automatic test_z_not_one();
        int lat; logic [7:0] rx, ry, rz;
        drive_op(1'b0, 8'd23, 8'd1, 8'd3, 8'd10, 8'd2, lat, rx, ry, rz);
        checks++; if ({rx, ry, rz} !== {8'd1, 8'd8, 8'd17}) begin errors++; $display("FAIL z2_point: got (%0d,%0d,%0d) expected (1,8,17)", rx, ry, rz); end
        release_out(1'b0);
        drive_op(1'b0, 8'd251, 8'd2, 8'd200, 8'd150, 8'd100, lat, rx, ry, rz);
        checks++; if (lat !== 104) begin errors++; $display("FAIL p251_latency: got %0d expected 104", lat); end
        checks++; if ({rx, ry, rz} !== {8'd101, 8'd72, 8'd131}) begin errors++; $display("FAIL p251_point: got (%0d,%0d,%0d) expected (101,72,131)", rx, ry, rz); end
        release_out(1'b0);
    endtask

    task automatic test_infinity();
        int lat; logic [7:0] rx, ry, rz;
        drive_op(1'b0, 8'd23, 8'd1, 8'd3, 8'd0, 8'd1, lat, rx, ry, rz);
        checks++; if (lat !== 2) begin errors++; $display("FAIL inf_y0_latency: got %0d expected 2", lat); end
        checks++; if ({rx, ry, rz} !== {8'd1, 8'd1, 8'd0}) begin errors++; $display("FAIL inf_y0_point: got (%0d,%0d,%0d) expected (1,1,0)", rx, ry, rz); end
        release_out(1'b0);
        drive_op(1'b0, 8'd251, 8'd2, 8'd200, 8'd150, 8'd0, lat, rx, ry, rz);
        checks++; if (lat !== 2 || {rx, ry, rz} !== {8'd1, 8'd1, 8'd0}) begin errors++; $display("FAIL inf_z0: got lat=%0d (%0d,%0d,%0d) expected lat=2 (1,1,0)", lat, rx, ry, rz); end
        release_out(1'b0);
        drive_op(1'b1, 8'd23, 8'd0, 8'd3, 8'd10, 8'd0, lat, rx, ry, rz);
        checks++; if (lat !== 2 || {rx, ry, rz} !== {8'd1, 8'd1, 8'd0}) begin errors++; $display("FAIL inf_azero: got lat=%0d (%0d,%0d,%0d) expected lat=2 (1,1,0)", lat, rx, ry, rz); end
        release_out(1'b1);
    endtask

    task automatic test_hold();
        int lat; logic [7:0] rx, ry, rz;
        drive_op(1'b0, 8'd23, 8'd1, 8'd3, 8'd10, 8'd1, lat, rx, ry, rz);
        checks++; if ({rx, ry, rz} !== {8'd17, 8'd21, 8'd20}) begin errors++; $display("FAIL hold_first: got (%0d,%0d,%0d) expected (17,21,20)", rx, ry, rz); end
        p = 8'd23; a = 8'd1; x1 = 8'd5; y1 = 8'd7; z1 = 8'd3;
        iv0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({x30, y30, z30} !== {8'd17, 8'd21, 8'd20} || rdy0 !== 1'b0 || ov0 !== 1'b1) begin
                errors++;
                $display("FAIL hold_cycle%0d: got (%0d,%0d,%0d) rdy=%b ov=%b expected (17,21,20) rdy=0 ov=1", i, x30, y30, z30, rdy0, ov0);
            end
        end
        iv0 = 1'b0;
        release_out(1'b0);
        @(negedge clk);
        checks++; if (ov0 !== 1'b0 || rdy0 !== 1'b1) begin errors++; $display("FAIL hold_release: got ov=%b rdy=%b expected ov=0 rdy=1", ov0, rdy0); end
        checks++; if ({x30, y30, z30} !== {8'd17, 8'd21, 8'd20}) begin errors++; $display("FAIL hold_idle_keep: got (%0d,%0d,%0d) expected (17,21,20)", x30, y30, z30); end
        drive_op(1'b0, 8'd23, 8'd1, 8'd3, 8'd10, 8'd2, lat, rx, ry, rz);
        checks++; if (lat !== 104 || {rx, ry, rz} !== {8'd1, 8'd8, 8'd17}) begin errors++; $display("FAIL hold_next_op: got lat=%0d (%0d,%0d,%0d) expected lat=104 (1,8,17)", lat, rx, ry, rz); end
        release_out(1'b0);
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [7:0] rx, ry, rz;
        @(negedge clk);
        p = 8'd23; a = 8'd1; x1 = 8'd3; y1 = 8'd10; z1 = 8'd2;
        iv0 = 1'b1;
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy0); end
        #2 nrst = 1'b0;
        #1;
        checks++; if (busy0 !== 1'b0 || rdy0 !== 1'b1 || ov0 !== 1'b0) begin errors++; $display("FAIL midrst_flags: got busy=%b rdy=%b ov=%b expected 0 1 0", busy0, rdy0, ov0); end
        checks++; if ({x30, y30, z30} !== 24'h0) begin errors++; $display("FAIL midrst_point: got (%0d,%0d,%0d) expected (0,0,0)", x30, y30, z30); end
        @(negedge clk);
        nrst = 1'b1;
        drive_op(1'b0, 8'd23, 8'd1, 8'd3, 8'd10, 8'd1, lat, rx, ry, rz);
        checks++; if (lat !== 104 || {rx, ry, rz} !== {8'd17, 8'd21, 8'd20}) begin errors++; $display("FAIL midrst_next_op: got lat=%0d (%0d,%0d,%0d) expected lat=104 (17,21,20)", lat, rx, ry, rz); end
        release_out(1'b0);
    endtask

    task automatic test_back_to_back();
        int lat; logic [7:0] rx, ry, rz;
        or1 = 1'b1;
        drive_op(1'b1, 8'd23, 8'd5, 8'd1, 8'd10, 8'd1, lat, rx, ry, rz);
        checks++; if (lat !== 76 || {rx, ry, rz} !== {8'd14, 8'd2, 8'd20}) begin errors++; $display("FAIL b2b_first: got lat=%0d (%0d,%0d,%0d) expected lat=76 (14,2,20)", lat, rx, ry, rz); end
        drive_op(1'b1, 8'd23, 8'd5, 8'd3, 8'd10, 8'd1, lat, rx, ry, rz);
        checks++; if (lat !== 76 || {rx, ry, rz} !== {8'd8, 8'd1, 8'd20}) begin errors++; $display("FAIL b2b_second: got lat=%0d (%0d,%0d,%0d) expected lat=76 (8,1,20)", lat, rx, ry, rz); end
        @(posedge clk);
        #1;
        or1 = 1'b0;
        @(negedge clk);
        checks++; if (ov1 !== 1'b0 || rdy1 !== 1'b1) begin errors++; $display("FAIL b2b_idle: got ov=%b rdy=%b expected ov=0 rdy=1", ov1, rdy1); end
    endtask

    initial begin
        nrst = 1'b0;
        iv0 = 1'b0; iv1 = 1'b0; or0 = 1'b0; or1 = 1'b0;
        p = '0; a = '0; x1 = '0; y1 = '0; z1 = '0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        test_reset();
        test_double_a1();
        test_double_azero();
        test_z_not_one();
        test_infinity();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
